mat4_stream_host: RTL and testbench
===================================

MAT4_STREAM_HOST -- requirements
Module: mat4_stream_host

Interface
REQ-001 SHALL have parameter LANE_W, default 64: bits per matrix element.
REQ-002 SHALL have parameter LANES, default 4: elements per operand.
REQ-003 SHALL have parameter TIMEOUT, default 255: WAIT-state cycle limit, used only with the watchdog.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1: upstream operand word valid.
REQ-007 SHALL have port in_ready, output, 1: host accepts an operand word.
REQ-008 SHALL have port in_data, input, LANE_W: operand word.
REQ-009 SHALL have port out_valid, output, 1: result word valid.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts a result word.
REQ-011 SHALL have port out_data, output, LANE_W: result word.
REQ-012 SHALL have port start, output, 1: one-cycle request to the mat4add engine.
REQ-013 SHALL have ports a and b, output, LANES*LANE_W: operand buses to the engine.
REQ-014 SHALL have port c, input, LANES*LANE_W: engine result bus.
REQ-015 SHALL have port done, input, 1: engine completion strobe.
REQ-016 SHALL have port busy, output, 1: high in every state except LOAD.
REQ-017 SHALL have port err, output, 1: watchdog expiry flag.

Function
REQ-018 SHALL implement the states LOAD, ISSUE, WAIT and DRAIN.
REQ-019 SHALL drive in_ready high only in LOAD; a word transfers on in_valid && in_ready.
REQ-020 SHALL use a 3-bit load count k, incremented per transfer: words 0..LANES-1 go to a[k*LANE_W +: LANE_W], words LANES..2*LANES-1 go to b; lane 0 first.
REQ-021 SHALL leave LOAD for ISSUE on the cycle after the 2*LANES-th transfer.
REQ-022 SHALL hold start high for exactly the one ISSUE cycle, then enter WAIT.
REQ-023 SHALL hold a and b stable from the final LOAD transfer until DRAIN completes.
REQ-024 SHALL sample done only in WAIT; done in any other state is ignored.
REQ-025 SHALL register c into an internal result buffer on the WAIT cycle where done=1, then enter DRAIN.
REQ-026 SHALL present the buffer in DRAIN as LANES words, lane 0 first, with out_valid=1.
REQ-027 SHALL advance one word per out_valid && out_ready and hold out_data and out_valid while out_ready=0.
REQ-028 SHALL return to LOAD (k=0) after the last DRAIN transfer, so in_ready=1 on the next cycle.
REQ-029 SHALL deliver the first result word no earlier than 2 cycles after done (done->DRAIN register, then output).
REQ-030 SHALL add no arithmetic; words pass through unmodified.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, set state=LOAD, k=0, a=b=0, result buffer=0, start=0, out_valid=0, err=0 and busy=0, regardless of state.
REQ-032 SHALL abandon any load, wait or drain in progress on a mid-operation reset; no partial result is emitted.

Configuration
REQ-033 SHALL compile the watchdog only with macro MAT4_HOST_TIMEOUT_EN defined.
REQ-034 SHALL, with MAT4_HOST_TIMEOUT_EN defined, count cycles in WAIT and, if done is absent for TIMEOUT cycles, set err=1, load zeros into the result buffer and enter DRAIN.
REQ-035 SHALL keep err set until the next ISSUE cycle or reset.
REQ-036 SHALL, without MAT4_HOST_TIMEOUT_EN, omit the counter, tie err to 0 and let WAIT wait indefinitely.

Structure
REQ-037 SHALL take the state enum and the LANE_W and LANES defaults from shared package mat4_pkg.
REQ-038 SHALL contain no sub-module; the watchdog counter is inline and the mat4add instance lives in the parent.

Verification
REQ-039 SHALL cover: in_data 1,2,3,4,1,2,3,4 with a model giving done 3 cycles after start and c=a+b per lane -> start pulses once, out_data 2,4,6,8.
REQ-040 SHALL cover: in_valid toggling 1/0 during LOAD -> a and b equal the sequence above; start fires exactly once after word 8.
REQ-041 SHALL cover: out_ready low for 5 cycles at word 2 -> out_data holds 4 with out_valid=1, then 6,8 follow.
REQ-042 SHALL cover: rst asserted in WAIT -> next cycle state=LOAD, in_ready=1, out_valid=0; a later done is ignored.
REQ-043 SHALL cover: with MAT4_HOST_TIMEOUT_EN and TIMEOUT=10, done never asserted -> err=1 after 10 WAIT cycles, out_data 0,0,0,0.
REQ-044 SHALL cover: done asserted during ISSUE and held low in WAIT -> the host stays in WAIT with no output.

Source files
------------

// File: rtl/mat4_pkg.sv
// Shared state encoding and default geometry for the mat4 stream host.
package mat4_pkg;

  localparam int MAT4_LANE_W = 64;
  localparam int MAT4_LANES  = 4;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/mat4_stream_host.sv
// Loads two LANES-word operands, pulses the mat4add engine, then streams its result out word by word.
// Optional WAIT watchdog (err flag, zero result) is compiled in with MAT4_HOST_TIMEOUT_EN.
module mat4_stream_host
  import mat4_pkg::*;
#(
  parameter int LANE_W  = MAT4_LANE_W,
  parameter int LANES   = MAT4_LANES,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANE_W-1:0]       in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANE_W-1:0]       out_data,
  output logic                    start,
  output logic [LANES*LANE_W-1:0] a,
  output logic [LANES*LANE_W-1:0] b,
  input  logic [LANES*LANE_W-1:0] c,
  input  logic                    done,
  output logic                    busy,
  output logic                    err
);

  // k is shared: load index (0..2*LANES-1) in LOAD, result word index in DRAIN.
  localparam logic [2:0] LAST_LOAD  = 3'(2 * LANES - 1);
  localparam logic [2:0] LAST_DRAIN = 3'(LANES - 1);

  state_t                  state, state_nxt;
  logic [2:0]              k;
  logic [2:0]              k_sel;
  logic [LANES*LANE_W-1:0] rbuf;
  logic [LANE_W-1:0]       rbuf_word;
  logic                    out_xfer;
  logic                    expired;

  assign out_xfer = out_valid && out_ready;

`ifdef MAT4_HOST_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;

  assign expired = (state == WAIT) && !done && (wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      wd_cnt <= (state == WAIT) ? wd_cnt + WD_W'(1) : '0;
      if (state == ISSUE)
        err <= 1'b0;
      else if (expired)
        err <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign expired        = 1'b0;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    start     = 1'b0;
    busy      = 1'b1;
    unique case (state)
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid && k == LAST_LOAD) state_nxt = ISSUE;
      end
      ISSUE: begin
        start     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:    if (done || expired) state_nxt = DRAIN;
      DRAIN:   if (out_xfer && k == LAST_DRAIN) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Prefetch the next result word so out_data changes on the same edge that accepts the current one.
  always_comb begin
    k_sel     = out_valid ? k + 3'd1 : k;
    rbuf_word = '0;
    for (int i = 0; i < LANES; i++)
      if (k_sel == 3'(i)) rbuf_word = rbuf[i*LANE_W +: LANE_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k         <= '0;
      a         <= '0;
      b         <= '0;
      rbuf      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      unique case (state)
        LOAD: if (in_valid) begin
          for (int i = 0; i < LANES; i++) begin
            if (k == 3'(i))         a[i*LANE_W +: LANE_W] <= in_data;
            if (k == 3'(LANES + i)) b[i*LANE_W +: LANE_W] <= in_data;
          end
          k <= (k == LAST_LOAD) ? 3'd0 : k + 3'd1;
        end
        WAIT: begin
          if (done)         rbuf <= c;
          else if (expired) rbuf <= '0;
        end
        DRAIN: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= rbuf_word;
          end else if (out_ready) begin
            if (k == LAST_DRAIN) begin
              out_valid <= 1'b0;
              k         <= 3'd0;
            end else begin
              k        <= k + 3'd1;
              out_data <= rbuf_word;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mat4_stream_host.sv
// Directed bench for mat4_stream_host with a behavioural mat4add engine and a result scoreboard.
module tb_mat4_stream_host;

  localparam int LW      = 64;
  localparam int LN      = 4;
  localparam int ENG_LAT = 3;
`ifdef MAT4_HOST_TIMEOUT_EN
  localparam int TB_TO = 10;
`else
  localparam int TB_TO = 255;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, out_valid, out_ready;
  logic [LW-1:0]   in_data, out_data;
  logic            start, done, busy, err;
  logic [LN*LW-1:0] a, b, c;

  always #5 clk = ~clk;

  mat4_stream_host #(.LANE_W(LW), .LANES(LN), .TIMEOUT(TB_TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .start(start), .a(a), .b(b), .c(c), .done(done),
    .busy(busy), .err(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [LN*LW-1:0] act, input logic [LN*LW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard state: operands seen on the input stream and the result words they must produce.
  logic [LW-1:0]    m_words [2*LN];
  int               m_cnt    = 0;
  bit               m_loaded = 1'b0;
  logic [LN*LW-1:0] m_a = '0, m_b = '0;
  logic [LW-1:0]    exp_q [$];
  logic [LW-1:0]    got_q [$];
  int               start_cnt = 0;
  bit               eng_en    = 1'b1;
  int               inj_req   = 0;

  function automatic logic [LN*LW-1:0] lane_sum(input logic [LN*LW-1:0] x, input logic [LN*LW-1:0] y);
    logic [LN*LW-1:0] r;
    for (int i = 0; i < LN; i++) r[i*LW +: LW] = x[i*LW +: LW] + y[i*LW +: LW];
    return r;
  endfunction

  initial begin : compare
    logic [LW-1:0] s;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        m_cnt = 0; m_loaded = 1'b0; m_a = '0; m_b = '0;
      end else begin
        if (in_valid && in_ready) begin
          m_words[m_cnt] = in_data;
          m_cnt++;
          if (m_cnt == 2*LN) begin
            m_cnt = 0;
            m_loaded = 1'b1;
            for (int i = 0; i < LN; i++) begin
              m_a[i*LW +: LW] = m_words[i];
              m_b[i*LW +: LW] = m_words[LN+i];
              s = m_words[i] + m_words[LN+i];
              exp_q.push_back(eng_en ? s : '0);
            end
          end
        end
        if (start) begin
          start_cnt++;
          chk("start_after_full_load", m_loaded, 1);
          m_loaded = 1'b0;
        end
        if (out_valid) begin
          if (exp_q.size() == 0) chk("spurious_out_valid", out_valid, 0);
          else begin
            chk("out_data", out_data, exp_q[0]);
            if (out_ready) begin
              got_q.push_back(out_data);
              void'(exp_q.pop_front());
            end
          end
        end
        chk("in_ready_vs_busy", in_ready, !busy);
        if (busy) begin
          chk("a_stable", a, m_a);
          chk("b_stable", b, m_b);
        end
`ifndef MAT4_HOST_TIMEOUT_EN
        chk("err_tied_low", err, 0);
`endif
      end
    end
  end

  // mat4add engine: done ENG_LAT cycles after start, c = a + b per lane; inj_req forces a stray done.
  initial begin : engine
    int eng_cnt, eng_seen, inj_ack;
    logic [LN*LW-1:0] eng_a, eng_b;
    eng_cnt = 0; eng_seen = 0; inj_ack = 0;
    eng_a = '0; eng_b = '0;
    done = 1'b0; c = '0;
    forever begin
      @(posedge clk);
      #2;
      done = 1'b0;
      if (inj_req != inj_ack) begin
        inj_ack = inj_req;
        done = 1'b1;
        c = {LN{64'hDEAD_BEEF_0BAD_F00D}};
      end
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          done = 1'b1;
          c = lane_sum(eng_a, eng_b);
        end
      end
      if (start_cnt != eng_seen) begin
        eng_seen = start_cnt;
        if (eng_en) begin
          eng_cnt = ENG_LAT - 1;
          eng_a = a;
          eng_b = b;
        end
      end
    end
  end

  logic [LW-1:0] vec [2*LN];

  task automatic send_word(input logic [LW-1:0] w);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) chk("in_ready_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic load_vec(input bit toggle);
    for (int i = 0; i < 2*LN; i++) begin
      if (toggle && i > 0) begin @(posedge clk); #1; end
      send_word(vec[i]);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && in_ready) && n < 300) begin @(negedge clk); n++; end
    chk("drain_complete", (exp_q.size() == 0 && in_ready), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_got(input string name, input int base,
                           input logic [LW-1:0] w0, input logic [LW-1:0] w1,
                           input logic [LW-1:0] w2, input logic [LW-1:0] w3);
    logic [LW-1:0] want [4];
    want = '{w0, w1, w2, w3};
    chk({name, "_count"}, got_q.size() - base, 4);
    for (int i = 0; i < 4; i++)
      if (got_q.size() > base + i) chk({name, "_word"}, got_q[base+i], want[i]);
  endtask

  initial begin : timeout_guard
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin : main
    int sc, gb, n;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_start", start, 0);
    chk("rst_err", err, 0);
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    @(posedge clk);
    #1;

    // Basic transaction, continuous input.
    vec = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd1, 64'd2, 64'd3, 64'd4};
    sc = start_cnt; gb = got_q.size();
    load_vec(1'b0);
    wait_idle();
    chk("t1_start_once", start_cnt - sc, 1);
    check_got("t1", gb, 64'd2, 64'd4, 64'd6, 64'd8);

    // in_valid toggling during LOAD.
    sc = start_cnt; gb = got_q.size();
    load_vec(1'b1);
    @(negedge clk);
    chk("t2_a", a, {64'd4, 64'd3, 64'd2, 64'd1});
    chk("t2_b", b, {64'd4, 64'd3, 64'd2, 64'd1});
    @(posedge clk);
    #1;
    wait_idle();
    chk("t2_start_once", start_cnt - sc, 1);
    check_got("t2", gb, 64'd2, 64'd4, 64'd6, 64'd8);

    // Downstream stall on the second result word.
    gb = got_q.size();
    load_vec(1'b0);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk("t3_first_word_seen", out_valid, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_data", out_data, 64'd4);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle();
    check_got("t3", gb, 64'd2, 64'd4, 64'd6, 64'd8);

    // Lane-width wraparound in the engine, words pass through unmodified.
    vec = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd7, 64'h0123_4567_89AB_CDEF,
            64'd1, 64'h8000_0000_0000_0000, 64'd9, 64'h1111_1111_1111_1111};
    gb = got_q.size();
    load_vec(1'b0);
    wait_idle();
    check_got("t4", gb, 64'd0, 64'd0, 64'd16, 64'h1234_5678_9ABC_DF00);

    // Reset while in WAIT; the engine's done arrives afterwards and must be ignored.
    vec = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd1, 64'd2, 64'd3, 64'd4};
    sc = start_cnt;
    load_vec(1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_busy", busy, 0);
    repeat (10) @(negedge clk);
    chk("t5_still_idle", in_ready, 1);
    chk("t5_one_start", start_cnt - sc, 1);
    chk("t5_a_cleared", a, 0);
    @(posedge clk);
    #1;

    // done pulsed during ISSUE only: host must keep waiting.
    eng_en = 1'b0;
    load_vec(1'b0);
    inj_req++;
    repeat (8) begin
      @(negedge clk);
      chk("t6_busy", busy, 1);
      chk("t6_no_out", out_valid, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    eng_en = 1'b1;
    @(negedge clk);
    chk("t6_recovered", in_ready, 1);
    @(posedge clk);
    #1;

`ifdef MAT4_HOST_TIMEOUT_EN
    // Watchdog expiry: zero result, err held until the next issue.
    eng_en = 1'b0;
    gb = got_q.size();
    load_vec(1'b0);
    n = 0;
    @(negedge clk);
    @(negedge clk);
    while (!err && n < 100) begin n++; @(negedge clk); end
    chk("t7_wait_cycles", n, 10);
    @(posedge clk);
    #1;
    wait_idle();
    check_got("t7", gb, 64'd0, 64'd0, 64'd0, 64'd0);
    chk("t7_err_held", err, 1);
    eng_en = 1'b1;
    gb = got_q.size();
    load_vec(1'b0);
    wait_idle();
    chk("t7_err_cleared", err, 0);
    check_got("t7b", gb, 64'd2, 64'd4, 64'd6, 64'd8);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
